// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, status bytes and the request-arbiter state/payload types.
package alu_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned RES_W  = 16;
  localparam int unsigned STAT_W = 8;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [OP_W-1:0] {
    CMD_ADD = 3'd0,
    CMD_SUB = 3'd1,
    CMD_MUL = 3'd2,
    CMD_AND = 3'd3,
    CMD_OR  = 3'd4,
    CMD_XOR = 3'd5,
    CMD_SHL = 3'd6
  } operation_t;

  localparam logic [STAT_W-1:0] S_NO_ERROR        = 8'h00;
  localparam logic [STAT_W-1:0] S_INVALID_COMMAND = 8'h01;
  localparam logic [STAT_W-1:0] S_TIMEOUT         = 8'h80;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // One operation as presented to the ALU; op is kept raw so unknown codes pass through.
  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OP_W-1:0]   op;
  } alu_cmd_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request after ptr, wrapping modulo N_REQ.
module rr_arbiter #(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDW-1:0]   gnt_idx,
  output logic             gnt_valid
);

  logic [IDW-1:0] cand;

  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    cand      = '0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      cand = IDW'((32'(ptr) + off) % N_REQ);
      if (!gnt_valid && req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one ALU among N_REQ requesters: round-robin accept, issue, wait/timeout, tagged response.
module alu_req_arbiter
  import alu_pkg::*;
#(
  parameter  int unsigned N_REQ   = 4,
  parameter  int unsigned TIMEOUT = 255,
  localparam int unsigned IDW     = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [DATA_W*N_REQ-1:0] req_a,
  input  logic [DATA_W*N_REQ-1:0] req_b,
  input  logic [OP_W*N_REQ-1:0]   req_op,
  output logic                    alu_start,
  output logic [DATA_W-1:0]       alu_a,
  output logic [DATA_W-1:0]       alu_b,
  output logic [OP_W-1:0]         alu_op,
  input  logic                    alu_done,
  input  logic [RES_W-1:0]        alu_result,
  input  logic [STAT_W-1:0]       alu_status,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IDW-1:0]          rsp_id,
  output logic [RES_W-1:0]        rsp_data,
  output logic [STAT_W-1:0]       rsp_status,
  output logic                    busy,
  output logic                    spurious_done
);

  arb_state_t          state_q, state_d;
  alu_cmd_t            cmd_q, cmd_d;
  logic [IDW-1:0]      id_q, id_d;
  logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [RES_W-1:0]    rsp_data_q, rsp_data_d;
  logic [STAT_W-1:0]   rsp_status_q, rsp_status_d;
  logic                alu_start_q, alu_start_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                busy_q, busy_d;
  logic                spurious_q, spurious_d;

  logic [N_REQ-1:0]    gnt;
  logic [IDW-1:0]      gnt_idx;
  logic                gnt_valid;
  alu_cmd_t            cmd_in [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign cmd_in[i] = {req_a[DATA_W*i +: DATA_W], req_b[DATA_W*i +: DATA_W], req_op[OP_W*i +: OP_W]};
  end

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  // Grant is only offered from IDLE and never while reset is held.
  assign req_ready = (rst_n && (state_q == IDLE)) ? gnt : '0;

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    id_d         = id_q;
    rr_ptr_d     = rr_ptr_q;
    cnt_d        = cnt_q;
    rsp_data_d   = rsp_data_q;
    rsp_status_d = rsp_status_q;
    alu_start_d  = 1'b0;
    spurious_d   = spurious_q | (alu_done && (state_q != WAIT));
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          cmd_d       = cmd_in[gnt_idx];
          id_d        = gnt_idx;
          alu_start_d = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A completion on the final counted cycle still beats the timeout.
        if (alu_done) begin
          rsp_data_d   = alu_result;
          rsp_status_d = alu_status;
          state_d      = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rsp_data_d   = '0;
          rsp_status_d = S_TIMEOUT;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rr_ptr_d = id_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    rsp_valid_d = (state_d == RESP);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cmd_q        <= '0;
      id_q         <= '0;
      rr_ptr_q     <= IDW'(N_REQ - 1);
      cnt_q        <= '0;
      rsp_data_q   <= '0;
      rsp_status_q <= '0;
      alu_start_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      spurious_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      id_q         <= id_d;
      rr_ptr_q     <= rr_ptr_d;
      cnt_q        <= cnt_d;
      rsp_data_q   <= rsp_data_d;
      rsp_status_q <= rsp_status_d;
      alu_start_q  <= alu_start_d;
      rsp_valid_q  <= rsp_valid_d;
      busy_q       <= busy_d;
      spurious_q   <= spurious_d;
    end
  end

  assign alu_start     = alu_start_q;
  assign alu_a         = cmd_q.a;
  assign alu_b         = cmd_q.b;
  assign alu_op        = cmd_q.op;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_id        = id_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_status    = rsp_status_q;
  assign busy          = busy_q;
  assign spurious_done = spurious_q;

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the single ALU between N_REQ requesters.
- Accepts one operation (A, B, op) per grant and issues it to the ALU with a start pulse.
- Waits for ALU completion, or times out, then returns result and status to the winning requester, tagged with its id.
- Sits between the requester agents/BFMs and the ALU; only one operation is in flight at a time.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT, 255, max cycles spent in WAIT before the operation is aborted (1..65535).
- IDW, $clog2(N_REQ), requester id width (derived, not to be overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  N_REQ  per-requester operation request.
- req_ready  out  N_REQ  one-hot grant/accept; transfer when valid & ready.
- req_a  in  8*N_REQ  operand A, requester i at [8i+7:8i].
- req_b  in  8*N_REQ  operand B, same packing.
- req_op  in  3*N_REQ  operation_t code, requester i at [3i+2:3i].
- alu_start  out  1  one-cycle start pulse to ALU.
- alu_a, alu_b  out  8 each  latched operands.
- alu_op  out  3  latched operation.
- alu_done  in  1  ALU completion strobe.
- alu_result  in  16  ALU data result, valid with alu_done.
- alu_status  in  8  ALU status byte, valid with alu_done.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  IDW  requester id of this response.
- rsp_data  out  16  result.
- rsp_status  out  8  status byte.
- busy  out  1  high in any state except IDLE.
- spurious_done  out  1  sticky flag; set when alu_done is seen outside WAIT.

Behaviour:
- Reset: all outputs 0; state IDLE; rr_ptr = N_REQ-1, so requester 0 has first priority.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant g = first i with req_valid[i]=1, searching from rr_ptr+1 modulo N_REQ.
  - req_ready[g]=1 combinationally in the same cycle; all other req_ready bits are 0.
  - On that edge, latch a/b/op and id=g, then go to ISSUE. No valid requests: stay in IDLE.
- ISSUE:
  - alu_start=1 for exactly one cycle; alu_a/b/op hold the latched values from ISSUE until RESP exits.
  - Clear timeout counter; go to WAIT.
- WAIT:
  - alu_done=1: register result/status into rsp_data/rsp_status, go to RESP.
  - Otherwise counter++. When counter==TIMEOUT-1 with no done: rsp_data=16'h0000, rsp_status=S_TIMEOUT, go to RESP.
  - alu_done on the timeout cycle wins (real result is returned).
- RESP:
  - rsp_valid=1; rsp_* held stable until rsp_valid & rsp_ready.
  - On that handshake: rr_ptr=id, go to IDLE. A new grant is possible the following cycle.
- Latency: accept at cycle T; alu_start at T+1; if done arrives at T+1+k (k>=1), rsp_valid at T+2+k. Minimum turnaround is accept to next accept in 4 cycles.
- Invalid op codes are forwarded unchanged; the status comes from the ALU (S_INVALID_COMMAND). The arbiter does not check op codes.
- alu_done in IDLE, ISSUE or RESP: ignored for data, sets spurious_done (cleared only by reset).
- req_valid dropped before grant: no transfer. Requests arriving during non-IDLE states wait; req_ready stays 0.
- Fairness: a continuously requesting requester is served within N_REQ grants.
- Reset mid-operation: immediate return to IDLE, no response emitted, pending ALU result discarded.

Decomposition:
- alu_pkg holds:
  - operation_t (existing).
  - S_NO_ERROR, S_INVALID_COMMAND (existing).
  - New S_TIMEOUT = 8'h80.
  - New arb_state_t {IDLE, ISSUE, WAIT, RESP}.
- One sub-module: rr_arbiter (combinational round-robin priority pick from req_valid and rr_ptr, returns one-hot grant and index). It is reusable elsewhere.

Test Plan:
- Single request: req 0, A=8'h0F, B=8'hF0, CMD_OR; ALU model done after 3 cycles with 16'h00FF -> alu_start one cycle after accept; rsp_id=0, rsp_data=16'h00FF, rsp_status=S_NO_ERROR; rsp_valid 4 cycles after alu_start.
- Fairness: all 4 valid continuously from reset, CMD_ADD A=i B=1 -> grant order 0,1,2,3,0; each rsp_data=i+1.
- Timeout: TIMEOUT=8, ALU never responds -> rsp_status=S_TIMEOUT, rsp_data=0 exactly 8 cycles after entering WAIT; a later alu_done pulse sets spurious_done.
- Backpressure: rsp_ready low for 5 cycles -> rsp_* stable, req_ready all 0, busy=1; next grant the cycle after the handshake.
- Invalid op: req 2, op=3'b111, ALU returns S_INVALID_COMMAND -> forwarded unchanged with rsp_id=2.
- Reset in WAIT: drop rst_n while waiting -> all outputs 0 immediately; after release, requester 0 wins over requester 3 when both are valid.
